// File: rtl/sd_param.sv
// -----------------------------------------------------------------------------
// sd_param - parametrised serial sequence detector
//
// Purpose:
//   Shifts accepted serial bits into a PAT_W-bit window and compares the window
//   with a pattern latched at start. It flags each match one clock after the
//   sampling edge and counts matches (saturating). It pulses done after SEQ_LEN
//   accepted bits. Matching can be overlapping or non-overlapping. In
//   non-overlapping mode the window fill restarts after a match, so the next
//   match needs PAT_W fresh bits.
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous reset, active low
//   start        in   1      pulse: latch cfg, clear window/counts, enter RUN
//   pattern_cfg  in   PAT_W  target pattern, MSB = oldest bit of the window
//   overlap_en   in   1      1 = overlapping matches, 0 = flush after a match
//   valid_in     in   1      pattern_in valid this cycle (used in RUN only)
//   pattern_in   in   1      serial data bit
//   Dout         out  1      registered match flag for the bit accepted last cycle
//   done         out  1      1-cycle pulse, coincident with the last bit's Dout
//   match_cnt    out  CNT_W  matches in the current/last run, held until start
//
// States:
//   S_IDLE | waiting for start; data inputs ignored
//   S_RUN  | accepting bits, matching, counting
//   S_DONE | one cycle after the SEQ_LEN-th accepted bit; returns to S_IDLE
// -----------------------------------------------------------------------------
module sd_param #(
  parameter int PAT_W   = 4,
  parameter int SEQ_LEN = 14,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern_cfg,
  input  logic             overlap_en,
  input  logic             valid_in,
  input  logic             pattern_in,
  output logic             Dout,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam int BCNT_W = $clog2(SEQ_LEN + 1);

  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_PM1  = FILL_W'(PAT_W - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(SEQ_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q,  state_d;
  logic [PAT_W-1:0]   pat_q,    pat_d;
  logic               ovl_q,    ovl_d;
  // Only the PAT_W-1 older bits need storing; the newest bit is pattern_in.
  logic [PAT_W-2:0]   win_q,    win_d;
  logic [FILL_W-1:0]  fill_q,   fill_d;
  logic [BCNT_W-1:0]  bcnt_q,   bcnt_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               dout_q,   dout_d;
  logic               done_q,   done_d;

  logic               accept;
  logic [PAT_W-1:0]   win_new;
  logic               hit;

  always_comb begin
    accept  = (state_q == S_RUN) && valid_in && !start;
    win_new = {win_q, pattern_in};
    // The old fill must already be PAT_W-1 so the new window is all real bits.
    hit     = accept && (fill_q >= FILL_PM1) && (win_new == pat_q);
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    ovl_d   = ovl_q;
    win_d   = win_q;
    fill_d  = fill_q;
    bcnt_d  = bcnt_q;
    cnt_d   = cnt_q;
    dout_d  = 1'b0;
    done_d  = 1'b0;

    if (start) begin
      // A restart from any state abandons the current run silently.
      state_d = S_RUN;
      pat_d   = pattern_cfg;
      ovl_d   = overlap_en;
      win_d   = '0;
      fill_d  = '0;
      bcnt_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_RUN: begin
          if (accept) begin
            win_d  = win_new[PAT_W-2:0];
            fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
            bcnt_d = bcnt_q + BCNT_W'(1);
            if (hit) begin
              dout_d = 1'b1;
              if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
              end
              if (!ovl_q) begin
                fill_d = '0;
              end
            end
            if (bcnt_q == BCNT_LAST) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      win_q   <= '0;
      fill_q  <= '0;
      bcnt_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      bcnt_q  <= bcnt_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  assign Dout      = dout_q;
  assign done      = done_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_sd_param.sv
// -----------------------------------------------------------------------------
// tb_sd_param - self-checking bench for sd_param
//
// Three instances share start/valid/data: a 4-bit detector (defaults), a 3-bit
// detector, and a 3-bit detector with a 3-bit match counter to exercise
// saturation. The reference model keeps the list of accepted bits. A match
// exists at accepted index k when the last PAT_W bits equal the pattern. In
// non-overlap mode, k must also be at least PAT_W past the previous match.
// -----------------------------------------------------------------------------
module tb_sd_param;

  localparam int SEQ_LEN = 14;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       overlap_en;
  logic       valid_in;
  logic       pattern_in;
  logic [3:0] pattern_cfg4;
  logic [2:0] pattern_cfg3;

  logic       dout4, done4;
  logic [4:0] cnt4;
  logic       dout3, done3;
  logic [4:0] cnt3;
  logic       dout3s, done3s;
  logic [2:0] cnt3s;

  sd_param #(.PAT_W(4), .SEQ_LEN(SEQ_LEN), .CNT_W(5)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern_cfg(pattern_cfg4),
    .overlap_en(overlap_en), .valid_in(valid_in), .pattern_in(pattern_in),
    .Dout(dout4), .done(done4), .match_cnt(cnt4)
  );

  sd_param #(.PAT_W(3), .SEQ_LEN(SEQ_LEN), .CNT_W(5)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern_cfg(pattern_cfg3),
    .overlap_en(overlap_en), .valid_in(valid_in), .pattern_in(pattern_in),
    .Dout(dout3), .done(done3), .match_cnt(cnt3)
  );

  sd_param #(.PAT_W(3), .SEQ_LEN(SEQ_LEN), .CNT_W(3)) u_dut3s (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern_cfg(pattern_cfg3),
    .overlap_en(overlap_en), .valid_in(valid_in), .pattern_in(pattern_in),
    .Dout(dout3s), .done(done3s), .match_cnt(cnt3s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // reference model state; index 0 = 4-bit pattern, 1 = 3-bit pattern
  bit running_m;
  bit ovl_m;
  bit hist[$];
  int pat_m [2];
  int last_m[2];
  int cnt_m [2];
  bit dout_m[2];
  bit done_m;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pw(input int m);
    return (m == 0) ? 4 : 3;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    running_m = 1'b0;
    hist.delete();
    for (int m = 0; m < 2; m++) begin
      last_m[m] = -1;
      cnt_m[m]  = 0;
      dout_m[m] = 1'b0;
    end
    done_m = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit v, input bit b);
    int k;
    int w;
    int val;
    done_m    = 1'b0;
    dout_m[0] = 1'b0;
    dout_m[1] = 1'b0;
    if (st) begin
      running_m = 1'b1;
      hist.delete();
      for (int m = 0; m < 2; m++) begin
        last_m[m] = -1;
        cnt_m[m]  = 0;
      end
      pat_m[0] = int'(pattern_cfg4);
      pat_m[1] = int'(pattern_cfg3);
      ovl_m    = overlap_en;
    end else if (running_m && v) begin
      hist.push_back(b);
      k = hist.size() - 1;
      for (int m = 0; m < 2; m++) begin
        w = pw(m);
        if (k >= w - 1 && (ovl_m || (k - last_m[m]) >= w)) begin
          val = 0;
          for (int j = k - w + 1; j <= k; j++) val = val * 2 + int'(hist[j]);
          if (val == pat_m[m]) begin
            dout_m[m] = 1'b1;
            cnt_m[m]++;
            if (!ovl_m) last_m[m] = k;
          end
        end
      end
      if (hist.size() == SEQ_LEN) begin
        done_m    = 1'b1;
        running_m = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    chk("dout4",  int'(dout4),  int'(dout_m[0]));
    chk("done4",  int'(done4),  int'(done_m));
    chk("cnt4",   int'(cnt4),   sat(cnt_m[0], 31));
    chk("dout3",  int'(dout3),  int'(dout_m[1]));
    chk("done3",  int'(done3),  int'(done_m));
    chk("cnt3",   int'(cnt3),   sat(cnt_m[1], 31));
    chk("dout3s", int'(dout3s), int'(dout_m[1]));
    chk("done3s", int'(done3s), int'(done_m));
    chk("cnt3s",  int'(cnt3s),  sat(cnt_m[1], 7));
  endtask

  // Called at a negedge: drive, clock, update the model, compare at next negedge.
  task automatic cycle(input logic st, input logic v, input logic b);
    start      = st;
    valid_in   = v;
    pattern_in = b;
    @(posedge clk);
    model_step(st, v, b);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run_bits(input logic [13:0] s, input int n, input int gap_at,
                          input int gap_len);
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b1, s[i]);
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  logic [13:0] s1;
  logic [13:0] s_ones;

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    valid_in     = 1'b0;
    pattern_in   = 1'b0;
    overlap_en   = 1'b1;
    pattern_cfg4 = 4'b1011;
    pattern_cfg3 = 3'b101;
    s1           = 14'b11011101101101; // bit 0 first: 1,0,1,1,0,1,1,0,1,1,1,0,1,1
    s_ones       = 14'h3fff;
    model_reset();

    @(negedge clk);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 1'b1); // idle input ignored
    chk("idle_cnt", int'(cnt4), 0);

    // test 1: overlap, 1011
    overlap_en = 1'b1;
    run_bits(s1, 14, -1, 0);
    chk("t1_cnt", int'(cnt4), 4);
    chk("t1_done", int'(done4), 1);
    cycle(1'b0, 1'b0, 1'b0);
    chk("t1_hold", int'(cnt4), 4);

    // test 2: non-overlap
    overlap_en = 1'b0;
    run_bits(s1, 14, -1, 0);
    chk("t2_cnt", int'(cnt4), 3);
    chk("t2_done", int'(done4), 1);
    cycle(1'b0, 1'b0, 1'b0);

    // test 3: valid gap of 3 cycles after bit 5
    overlap_en = 1'b1;
    run_bits(s1, 14, 5, 3);
    chk("t3_cnt", int'(cnt4), 4);
    chk("t3_done", int'(done4), 1);
    cycle(1'b0, 1'b0, 1'b0);

    // test 4: 3-bit 111 on all ones, overlap then non-overlap
    pattern_cfg3 = 3'b111;
    overlap_en   = 1'b1;
    run_bits(s_ones, 14, -1, 0);
    chk("t4o_cnt3", int'(cnt3), 12);
    chk("t4o_cnt3s", int'(cnt3s), 7);
    cycle(1'b0, 1'b0, 1'b0);
    overlap_en = 1'b0;
    run_bits(s_ones, 14, -1, 0);
    chk("t4n_cnt3", int'(cnt3), 4);
    chk("t4n_cnt3s", int'(cnt3s), 4);
    cycle(1'b0, 1'b0, 1'b0);

    // test 5: restart after bit 7
    overlap_en = 1'b1;
    run_bits(s1, 8, -1, 0);
    cycle(1'b1, 1'b1, 1'b1);
    chk("t5_clr", int'(cnt4), 0);
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b1, s1[i]);
    chk("t5_cnt", int'(cnt4), 4);
    chk("t5_done", int'(done4), 1);
    cycle(1'b0, 1'b0, 1'b0);

    // test 6: async reset between edges mid-run
    run_bits(s1, 7, -1, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    run_bits(s1, 14, -1, 0);
    chk("t6_cnt", int'(cnt4), 4);
    cycle(1'b0, 1'b0, 1'b0);

    // randomized runs: random cfg, gaps, mid-run cfg changes, rare restarts
    for (int r = 0; r < 60; r++) begin
      pattern_cfg4 = 4'($urandom_range(0, 15));
      pattern_cfg3 = 3'($urandom_range(0, 7));
      overlap_en   = 1'($urandom_range(0, 1));
      cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 9) == 0) begin
          pattern_cfg4 = 4'($urandom_range(0, 15));
          pattern_cfg3 = 3'($urandom_range(0, 7));
          overlap_en   = 1'($urandom_range(0, 1));
        end
        cycle(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)));
        if (!running_m) break;
      end
      for (int c = 0; c < 2; c++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
